// File: rtl/ahbl_master_monitor.sv
// ahbl_master_monitor
// Passive run-time protocol checker for one AHB-Lite master port. It watches
// the address phase, data phase and response signals and evaluates ten rules
// every cycle. Any violation is held in a sticky flag for its rule, counted in
// a saturating counter, and the lowest rule of the first violating cycle is
// captured. Results appear one cycle after the offending bus cycle.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   src_h*                observed AHB-Lite master/slave signals
//   clr_errs              clears flags, counter and first-error capture
//   err_flags[9:0]        sticky per-rule flags
//                         (0 ALIGN, 1 SIZE, 2 STABLE, 3 SEQ_ORDER, 4 SEQ_ADDR,
//                          5 BURST_LEN, 6 EXCL_PIPE, 7 WDATA_STABLE,
//                          8 EXCL_RESV, 9 TIMEOUT)
//   err_any               OR of err_flags
//   err_count             saturating count of cycles with at least one violation
//   first_err             lowest rule of the first violating cycle, 4'hf = none
module ahbl_master_monitor #(
  parameter int         W_ADDR   = 32,
  parameter int         W_DATA   = 32,
  parameter int         W_CNT    = 16,
  parameter int         TIMEOUT  = 1024,
  parameter logic [9:0] ERR_MASK = 10'h3ff
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_hready,
  input  logic              src_hresp,
  input  logic              src_hexokay,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic              src_hexcl,
  input  logic [W_DATA-1:0] src_hwdata,
  input  logic [W_DATA-1:0] src_hrdata,
  input  logic              clr_errs,
  output logic [9:0]        err_flags,
  output logic              err_any,
  output logic [W_CNT-1:0]  err_count,
  output logic [3:0]        first_err
);

  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NSEQ = 2'b10, HT_SEQ = 2'b11;
  localparam int         W_TO    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W_TO-1:0] TO_MAX = W_TO'(TIMEOUT);
  localparam logic [W_TO-1:0] TO_M1  = W_TO'(TIMEOUT - 1);

  // Read data carries no protocol rule; it is observed only.
  logic w_unused;
  assign w_unused = ^src_hrdata;

  // Address-phase snapshot for the stability rule
  logic              r_ap_pend;
  logic [1:0]        r_ap_trans;
  logic              r_ap_write, r_ap_lock;
  logic [W_ADDR-1:0] r_ap_addr;
  logic [2:0]        r_ap_size, r_ap_burst;
  logic [3:0]        r_ap_prot;
  // Data-phase trackers
  logic              r_dp_active, r_dp_write, r_dp_excl, r_resv;
  logic              r_wstall;
  logic [W_DATA-1:0] r_hwdata_q;
  // Burst tracker
  logic              r_bst_open;
  logic [4:0]        r_bst_beat;
  logic [W_ADDR-1:0] r_bst_addr;
  logic [2:0]        r_bst_size, r_bst_burst;
  // Stall counter and results
  logic [W_TO-1:0]   r_stall_cnt;
  logic [9:0]        r_flags;
  logic [W_CNT-1:0]  r_count;
  logic [3:0]        r_first;

  logic              w_act, w_fixed, w_wrap;
  logic [4:0]        w_len;
  logic [W_ADDR-1:0] w_step, w_inc, w_wrap_m, w_exp_addr, w_align_m;
  logic [9:0]        w_rules, w_viol;
  logic [3:0]        w_low, w_first_base;

  assign w_act = (src_htrans != HT_IDLE);

  // Beat count and next-address prediction for the open burst
  always_comb begin
    unique case (r_bst_burst[2:1])
      2'b01:   w_len = 5'd4;
      2'b10:   w_len = 5'd8;
      2'b11:   w_len = 5'd16;
      default: w_len = 5'd0;
    endcase
    w_fixed    = (r_bst_burst[2:1] != 2'b00);
    w_wrap     = w_fixed && !r_bst_burst[0];
    w_step     = W_ADDR'(1) << r_bst_size;
    w_inc      = r_bst_addr + w_step;
    w_wrap_m   = (W_ADDR'(w_len) << r_bst_size) - W_ADDR'(1);
    w_exp_addr = w_wrap ? ((r_bst_addr & ~w_wrap_m) | (w_inc & w_wrap_m)) : w_inc;
    w_align_m  = (W_ADDR'(1) << src_hsize) - W_ADDR'(1);
  end

  always_comb begin
    w_rules    = '0;
    w_rules[0] = w_act && ((src_haddr & w_align_m) != '0);
    w_rules[1] = w_act && ((32'd8 << src_hsize) > 32'(W_DATA));
    // hresp in the held cycle already cleared r_ap_pend, exempting error responses
    w_rules[2] = w_act && r_ap_pend &&
                 ({src_htrans, src_hwrite, src_haddr, src_hsize, src_hburst, src_hprot, src_hmastlock} !=
                  {r_ap_trans, r_ap_write, r_ap_addr, r_ap_size, r_ap_burst, r_ap_prot, r_ap_lock});
    w_rules[3] = ((src_htrans == HT_SEQ) || (src_htrans == HT_BUSY)) && !r_bst_open;
    w_rules[4] = (src_htrans == HT_SEQ) && r_bst_open && (src_haddr != w_exp_addr);
    w_rules[5] = r_bst_open && w_fixed &&
                 (((src_htrans == HT_SEQ) && (r_bst_beat >= w_len)) ||
                  (((src_htrans == HT_IDLE) || (src_htrans == HT_NSEQ)) &&
                   (r_bst_beat < w_len) && !src_hresp));
    w_rules[6] = w_act && src_htrans[1] && src_hexcl && r_dp_active && r_dp_excl;
    w_rules[7] = r_dp_active && r_wstall && (src_hwdata != r_hwdata_q);
    w_rules[8] = r_dp_active && r_dp_write && r_dp_excl && !r_resv;
    w_rules[9] = (TIMEOUT != 0) && w_act && !src_hready && (r_stall_cnt == TO_M1);
  end

  assign w_viol       = w_rules & ERR_MASK;
  assign w_first_base = clr_errs ? 4'hf : r_first;

  always_comb begin
    w_low = 4'hf;
    for (int i = 9; i >= 0; i--)
      if (w_viol[i]) w_low = 4'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ap_pend   <= 1'b0;
      r_ap_trans  <= HT_IDLE;
      r_ap_write  <= 1'b0;
      r_ap_lock   <= 1'b0;
      r_ap_addr   <= '0;
      r_ap_size   <= '0;
      r_ap_burst  <= '0;
      r_ap_prot   <= '0;
      r_dp_active <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_excl   <= 1'b0;
      r_resv      <= 1'b0;
      r_wstall    <= 1'b0;
      r_hwdata_q  <= '0;
      r_bst_open  <= 1'b0;
      r_bst_beat  <= '0;
      r_bst_addr  <= '0;
      r_bst_size  <= '0;
      r_bst_burst <= '0;
      r_stall_cnt <= '0;
      r_flags     <= '0;
      r_count     <= '0;
      r_first     <= 4'hf;
    end else begin
      // A pending transfer held by a wait state must keep its address phase
      r_ap_pend  <= src_htrans[1] && !src_hready && !src_hresp;
      r_ap_trans <= src_htrans;
      r_ap_write <= src_hwrite;
      r_ap_lock  <= src_hmastlock;
      r_ap_addr  <= src_haddr;
      r_ap_size  <= src_hsize;
      r_ap_burst <= src_hburst;
      r_ap_prot  <= src_hprot;

      r_wstall   <= r_dp_active && r_dp_write && !src_hready;
      r_hwdata_q <= src_hwdata;

      if (src_hready) begin
        if (r_dp_active && r_dp_excl) r_resv <= src_hexokay && !r_dp_write;
        r_dp_active <= src_htrans[1];
        r_dp_write  <= src_hwrite;
        r_dp_excl   <= src_hexcl && src_htrans[1];
      end

      if (src_hready && (src_htrans == HT_NSEQ)) begin
        r_bst_open  <= 1'b1;
        r_bst_beat  <= 5'd1;
        r_bst_addr  <= src_haddr;
        r_bst_size  <= src_hsize;
        r_bst_burst <= src_hburst;
      end else if (src_hresp) begin
        r_bst_open <= 1'b0;
      end else if (src_hready && r_bst_open) begin
        // With beat == len, this accepted cycle completes the final data phase
        if ((w_fixed && (r_bst_beat >= w_len)) || (src_htrans == HT_IDLE)) begin
          r_bst_open <= 1'b0;
        end else if (src_htrans == HT_SEQ) begin
          r_bst_beat <= r_bst_beat + 5'd1;
          r_bst_addr <= src_haddr;
        end
      end

      if (src_hready)                 r_stall_cnt <= '0;
      else if (r_stall_cnt != TO_MAX) r_stall_cnt <= r_stall_cnt + W_TO'(1);

      r_flags <= (clr_errs ? 10'd0 : r_flags) | w_viol;
      if (clr_errs)                                r_count <= (w_viol != '0) ? W_CNT'(1) : '0;
      else if ((w_viol != '0) && (r_count != '1)) r_count <= r_count + W_CNT'(1);
      r_first <= ((w_first_base == 4'hf) && (w_viol != '0)) ? w_low : w_first_base;
    end
  end

  assign err_flags = r_flags;
  assign err_any   = |r_flags;
  assign err_count = r_count;
  assign first_err = r_first;

endmodule

// File: tb/tb_ahbl_master_monitor.sv
// Directed bench for ahbl_master_monitor. Instance A runs with a short stall
// timeout and the ALIGN rule masked; instance B keeps every rule enabled but
// has the timeout disabled. Both watch the same bus.
module tb_ahbl_master_monitor;
  localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'd0, WR4 = 3'd2, IN4 = 3'd3;
  localparam logic [3:0] NF  = 4'hf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hready = 1'b1, hresp = 1'b0, hexokay = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, hrdata = 32'hdead_beef;
  logic        hwrite = 1'b0, hmastlock = 1'b0, hexcl = 1'b0, clr = 1'b0;
  logic [1:0]  htrans = IDL;
  logic [2:0]  hsize = 3'd2, hburst = SGL;
  logic [3:0]  hprot = 4'h3;
  logic [9:0]  a_flags, b_flags;
  logic        a_any, b_any;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  a_first, b_first;

  always #5 clk = ~clk;

  ahbl_master_monitor #(.TIMEOUT(8), .ERR_MASK(10'h3fe)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_hready(hready), .src_hresp(hresp), .src_hexokay(hexokay),
    .src_haddr(haddr), .src_hwrite(hwrite), .src_htrans(htrans), .src_hsize(hsize),
    .src_hburst(hburst), .src_hprot(hprot), .src_hmastlock(hmastlock), .src_hexcl(hexcl),
    .src_hwdata(hwdata), .src_hrdata(hrdata), .clr_errs(clr),
    .err_flags(a_flags), .err_any(a_any), .err_count(a_cnt), .first_err(a_first));

  ahbl_master_monitor #(.TIMEOUT(0), .ERR_MASK(10'h3ff)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_hready(hready), .src_hresp(hresp), .src_hexokay(hexokay),
    .src_haddr(haddr), .src_hwrite(hwrite), .src_htrans(htrans), .src_hsize(hsize),
    .src_hburst(hburst), .src_hprot(hprot), .src_hmastlock(hmastlock), .src_hexcl(hexcl),
    .src_hwdata(hwdata), .src_hrdata(hrdata), .clr_errs(clr),
    .err_flags(b_flags), .err_any(b_any), .err_count(b_cnt), .first_err(b_first));

  typedef struct {
    logic rst, clr;
    logic [1:0] tr;
    logic [31:0] addr;
    logic wr;
    logic [2:0] sz, bu;
    logic ex, rdy, resp, okay;
    logic [31:0] wd;
    logic [9:0] ef;
    logic [15:0] ec;
    logic [3:0] fe;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic row(input logic rst, input logic c, input logic [1:0] tr, input logic [31:0] addr,
                     input logic wr, input logic [2:0] sz, input logic [2:0] bu, input logic ex,
                     input logic rdy, input logic resp, input logic okay, input logic [31:0] wd,
                     input logic [9:0] ef, input logic [15:0] ec, input logic [3:0] fe);
    vec_t v;
    v.rst = rst; v.clr = c; v.tr = tr; v.addr = addr; v.wr = wr; v.sz = sz; v.bu = bu;
    v.ex = ex; v.rdy = rdy; v.resp = resp; v.okay = okay; v.wd = wd;
    v.ef = ef; v.ec = ec; v.fe = fe;
    tbl.push_back(v);
  endtask

  task automatic rst_row();
    row(1, 0, IDL, 0, 0, 2, SGL, 0, 1, 0, 0, 0, 10'h0, 0, NF);
  endtask

  // Drive one bus cycle and step past the following rising edge
  task automatic drv(input vec_t v);
    rst_n = !v.rst; clr = v.clr; htrans = v.tr; haddr = v.addr; hwrite = v.wr;
    hsize = v.sz; hburst = v.bu; hexcl = v.ex; hready = v.rdy; hresp = v.resp;
    hexokay = v.okay; hwdata = v.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic hand(input logic [1:0] tr, input logic [31:0] addr, input logic rdy, input logic rst);
    vec_t v;
    v.rst = rst; v.clr = 0; v.tr = tr; v.addr = addr; v.wr = 0; v.sz = 3'd2; v.bu = SGL;
    v.ex = 0; v.rdy = rdy; v.resp = 0; v.okay = 0; v.wd = 0;
    v.ef = 0; v.ec = 0; v.fe = NF;
    drv(v);
  endtask

  initial begin
    // Exclusive pair with reservation granted, then refused
    rst_row();
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h100,  0,2,SGL,1,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,1,0,     10'h000,0,NF);
    row(0,0,NSQ,'h100,  1,2,SGL,1,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,'h55,  10'h000,0,NF);
    row(0,0,NSQ,'h100,  0,2,SGL,1,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h100,  1,2,SGL,1,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,'h66,  10'h100,1,4'd8);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h100,1,4'd8);
    // WRAP4 word burst: legal wrap, then a beat that fails to wrap
    rst_row();
    row(0,0,NSQ,'h38,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h3C,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h30,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h34,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h38,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h3C,   0,2,WR4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h40,   0,2,WR4,0,1,0,0,0,     10'h010,1,4'd4);
    row(0,0,SQ, 'h44,   0,2,WR4,0,1,0,0,0,     10'h010,1,4'd4);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h010,1,4'd4);
    // INCR4 cut short by IDLE
    rst_row();
    row(0,0,NSQ,'h0,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h4,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h020,1,4'd5);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h020,1,4'd5);
    // Reset mid-burst forgets the open burst
    row(0,0,NSQ,'h0,    0,2,IN4,0,1,0,0,0,     10'h020,1,4'd5);
    row(0,0,SQ, 'h4,    0,2,IN4,0,1,0,0,0,     10'h020,1,4'd5);
    rst_row();
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    // Same cut-short burst with an ERROR response on beat 2
    row(0,0,NSQ,'h0,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h4,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,0,1,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,1,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    // INCR4 given a fifth SEQ
    row(0,0,NSQ,'h0,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h4,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h8,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'hC,    0,2,IN4,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h10,   0,2,IN4,0,1,0,0,0,     10'h020,1,4'd5);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h020,1,4'd5);
    // Address changed under a wait state, then clear, then write-data change under a wait state
    rst_row();
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h200,  0,2,SGL,0,0,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h204,  0,2,SGL,0,0,0,0,0,     10'h004,1,4'd2);
    row(0,0,NSQ,'h204,  0,2,SGL,0,1,0,0,0,     10'h004,1,4'd2);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h004,1,4'd2);
    row(0,1,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,NSQ,'h300,  1,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,0,0,0,'hA,   10'h000,0,NF);
    row(0,0,IDL,0,      0,2,SGL,0,0,0,0,'hB,   10'h080,1,4'd7);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,'hB,   10'h080,1,4'd7);
    // Masked ALIGN, then clear coinciding with a SIZE violation
    rst_row();
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h000,0,NF);
    row(0,0,SQ, 'h0,    0,2,SGL,0,1,0,0,0,     10'h008,1,4'd3);
    row(0,0,NSQ,'h102,  0,2,SGL,0,1,0,0,0,     10'h008,1,4'd3);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h008,1,4'd3);
    row(0,1,NSQ,'h108,  0,3,SGL,0,1,0,0,0,     10'h002,1,4'd1);
    row(0,0,IDL,0,      0,2,SGL,0,1,0,0,0,     10'h002,1,4'd1);

    #1;
    foreach (tbl[i]) begin
      drv(tbl[i]);
      chk($sformatf("r%0d.flags", i), 32'(a_flags), 32'(tbl[i].ef));
      chk($sformatf("r%0d.any",   i), 32'(a_any),   32'(tbl[i].ef != 0));
      chk($sformatf("r%0d.count", i), 32'(a_cnt),   32'(tbl[i].ec));
      chk($sformatf("r%0d.first", i), 32'(a_first), 32'(tbl[i].fe));
    end

    // Unmasked ALIGN on instance B only
    hand(IDL, 0, 1, 1);
    hand(IDL, 0, 1, 0);
    hand(NSQ, 'h102, 1, 0);
    chk("align.a_flags", 32'(a_flags), 32'h000);
    chk("align.b_flags", 32'(b_flags), 32'h001);
    chk("align.b_first", 32'(b_first), 32'h0);
    chk("align.b_count", 32'(b_cnt),   32'h1);
    hand(IDL, 0, 1, 0);
    // Stall a held NSEQ: rule fires on the 8th low cycle, once only
    hand(NSQ, 'h400, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      hand(NSQ, 'h404, 0, 0);
      chk($sformatf("to.k%0d.flags", k), 32'(a_flags), (k < 8) ? 32'h000 : 32'h200);
    end
    chk("to.first", 32'(a_first), 32'h9);
    hand(NSQ, 'h404, 1, 0);
    chk("to.count",   32'(a_cnt),   32'h1);
    chk("to.b_flags", 32'(b_flags), 32'h001);
    chk("to.b_count", 32'(b_cnt),   32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
